// File: rtl/reg_file_p.sv
// Two-read/one-write register file with a power-up zero sweep and registered reads.
// Define REG_FILE_BYPASS_EN for write-first forwarding on same-address read/write; default is read-first.
module reg_file_p #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid,
  output logic              ready,
  output logic              addr_err
);

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweepCnt;
  logic [WIDTH-1:0]  entry [DEPTH];

  logic             running;
  logic             wInRange;
  logic             aInRange;
  logic             bInRange;
  logic             doWrite;
  logic             fwdA;
  logic             fwdB;
  logic             accessErr;
  logic [WIDTH-1:0] readA;
  logic [WIDTH-1:0] readB;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned (no latch).
  always_comb begin
    running   = (state == RUN);
    wInRange  = ({1'b0, waddr}   < DEPTH_X);
    aInRange  = ({1'b0, raddr_a} < DEPTH_X);
    bInRange  = ({1'b0, raddr_b} < DEPTH_X);
    doWrite   = running && we && wInRange;
    accessErr = (we && !wInRange) || (re && (!aInRange || !bInRange));
`ifdef REG_FILE_BYPASS_EN
    fwdA      = doWrite && (raddr_a == waddr);
    fwdB      = doWrite && (raddr_b == waddr);
`else
    fwdA      = 1'b0;
    fwdB      = 1'b0;
`endif
    readA     = '0;
    readB     = '0;
    if (aInRange) readA = fwdA ? wdata : entry[raddr_a];
    if (bInRange) readB = fwdB ? wdata : entry[raddr_b];
  end

  assign ready = running;

  // NOTE: the storage array is deliberately not reset; the sweep zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (!running)
        entry[sweepCnt] <= '0;
      else if (doWrite)
        entry[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= SWEEP;
      sweepCnt <= '0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
    end else if (!running) begin
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
      if (sweepCnt == LAST_IDX) begin
        state    <= RUN;
        sweepCnt <= '0;
      end else begin
        sweepCnt <= sweepCnt + 1'b1;
      end
    end else begin
      rvalid   <= re;
      addr_err <= accessErr;
      if (re) begin
        rdata_a <= readA;
        rdata_b <= readB;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_p.sv
// Bench for reg_file_p: a DEPTH=16 and a DEPTH=12 instance driven in lockstep and compared
// every cycle against a countdown/array model, plus directed tables and sequences.
module tb_reg_file_p;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, we, re;
  logic [3:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata;
  logic [15:0] rdA16, rdB16, rdA12, rdB12;
  logic        rv16, rdy16, err16, rv12, rdy12, err12;

  int nChecks = 0;
  int nFails  = 0;

  reg_file_p #(.WIDTH(16), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdA16), .rdata_b(rdB16),
    .rvalid(rv16), .ready(rdy16), .addr_err(err16)
  );

  reg_file_p #(.WIDTH(16), .DEPTH(12), .ADDR_W(4)) dut12 (
    .clk(clk), .clear(clear), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdA12), .rdata_b(rdB12),
    .rvalid(rv12), .ready(rdy12), .addr_err(err12)
  );

  // Reference model: index 0 is the DEPTH=16 instance, index 1 the DEPTH=12 instance.
  int          depthOf [2] = '{16, 12};
  int          mLeft   [2];
  logic [15:0] mMem    [2][16];
  logic [15:0] mA      [2];
  logic [15:0] mB      [2];
  logic        mV      [2];
  logic        mE      [2];

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] expA;
    logic [15:0] expB;
    logic        expValid;
    logic        expErr;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input int n);
    bit inW, inA, inB;
    if (clear) begin
      mLeft[n] = depthOf[n];
      mA[n] = '0; mB[n] = '0; mV[n] = 1'b0; mE[n] = 1'b0;
    end else if (mLeft[n] > 0) begin
      mLeft[n]--;
      if (mLeft[n] == 0)
        for (int i = 0; i < depthOf[n]; i++) mMem[n][i] = '0;
      mV[n] = 1'b0; mE[n] = 1'b0;
    end else begin
      inW = int'(waddr)   < depthOf[n];
      inA = int'(raddr_a) < depthOf[n];
      inB = int'(raddr_b) < depthOf[n];
      if (re) begin
        mA[n] = !inA ? 16'h0 : (BYPASS && we && inW && raddr_a == waddr) ? wdata : mMem[n][raddr_a];
        mB[n] = !inB ? 16'h0 : (BYPASS && we && inW && raddr_b == waddr) ? wdata : mMem[n][raddr_b];
      end
      mV[n] = re;
      mE[n] = (we && !inW) || (re && (!inA || !inB));
      if (we && inW) mMem[n][waddr] = wdata;
    end
  endtask

  task automatic compareModel();
    check("m16_ready",  rdy16, mLeft[0] == 0);
    check("m16_rvalid", rv16,  mV[0]);
    check("m16_err",    err16, mE[0]);
    check("m16_rdA",    rdA16, mA[0]);
    check("m16_rdB",    rdB16, mB[0]);
    check("m12_ready",  rdy12, mLeft[1] == 0);
    check("m12_rvalid", rv12,  mV[1]);
    check("m12_err",    err12, mE[1]);
    check("m12_rdA",    rdA12, mA[1]);
    check("m12_rdB",    rdB12, mB[1]);
  endtask

  // Called at a falling edge: drive, clock once, update model, compare at the next falling edge.
  task automatic step(input logic c, input logic w, input logic [3:0] wa, input logic [15:0] wd,
                      input logic r, input logic [3:0] a, input logic [3:0] b);
    clear = c; we = w; waddr = wa; wdata = wd; re = r; raddr_a = a; raddr_b = b;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    compareModel();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  16'hA5A5, 1'b0, 4'd0,  4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  4'd3,  16'hA5A5, 16'hA5A5, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  4'd0,  16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'd5,  16'h1111, 1'b0, 4'd0,  4'd0,  16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd5,  16'h2222, 1'b1, 4'd5,  4'd3,
                BYPASS ? 16'h2222 : 16'h1111, 16'hA5A5, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  4'd5,  16'h2222, 16'h2222, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  4'd15, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd15, 4'd0,
                BYPASS ? 16'hFFFF : 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};

    clear = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd2, 16'h1234, 1'b1, 4'd2, 4'd2);
    check("rst_ready",  rdy16, 1'b0);
    check("rst_rvalid", rv16,  1'b0);
    check("rst_err",    err16, 1'b0);
    check("rst_rdA",    rdA16, 16'h0);
    check("rst_rdB",    rdB16, 16'h0);

    // Sweep length after release: 16 cycles for DEPTH=16, 12 for DEPTH=12.
    for (int k = 1; k <= 16; k++) begin
      idle();
      check($sformatf("sweep16_ready_k%0d", k), rdy16, k >= 16);
      check($sformatf("sweep12_ready_k%0d", k), rdy12, k >= 12);
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 4'(15 - i));
      check($sformatf("zero_rdA_%0d", i), rdA16, 16'h0);
      check($sformatf("zero_rdB_%0d", i), rdB16, 16'h0);
      check("zero_rvalid", rv16, 1'b1);
    end

    // Out-of-range access on the DEPTH=12 instance.
    step(1'b0, 1'b1, 4'd13, 16'hBEEF, 1'b0, 4'd0, 4'd0);
    check("oor_wr_err12", err12, 1'b1);
    check("oor_wr_err16", err16, 1'b0);
    idle();
    check("oor_wr_err12_drop", err12, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd13, 4'd13);
    check("oor_rd_rdA12",  rdA12, 16'h0);
    check("oor_rd_rdB12",  rdB12, 16'h0);
    check("oor_rd_err12",  err12, 1'b1);
    check("oor_rd_rv12",   rv12,  1'b1);
    check("inrange_rdA16", rdA16, 16'hBEEF);
    idle();
    check("oor_rd_err12_drop", err12, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 4'(i));
      check($sformatf("d12_intact_%0d", i), rdA12, 16'h0);
    end

    for (int v = 0; v < 9; v++) begin
      step(1'b0, vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].re, vecs[v].ra, vecs[v].rb);
      check($sformatf("vec%0d_rdA", v),    rdA16, vecs[v].expA);
      check($sformatf("vec%0d_rdB", v),    rdB16, vecs[v].expB);
      check($sformatf("vec%0d_rvalid", v), rv16,  vecs[v].expValid);
      check($sformatf("vec%0d_err", v),    err16, vecs[v].expErr);
    end

    // Clear at sweep counter 7, then accesses issued during the restarted sweep.
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k < 7; k++) idle();
    check("mid_sweep_ready", rdy16, 1'b0);
    step(1'b1, 1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd0, 4'd0);
    check("reclear_rdA",    rdA16, 16'h0);
    check("reclear_rvalid", rv16,  1'b0);
    for (int k = 1; k <= 16; k++) begin
      if (k >= 2 && k <= 12) step(1'b0, 1'b1, 4'd0, 16'h5A5A, 1'b1, 4'd0, 4'd13);
      else idle();
      check($sformatf("resweep_ready_k%0d", k), rdy16, k >= 16);
      check($sformatf("resweep_rv_k%0d", k),    rv16,  1'b0);
      check($sformatf("resweep_err12_k%0d", k), err12, 1'b0);
      check($sformatf("resweep_rdA_k%0d", k),   rdA16, 16'h0);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0);
    check("sweep_nowrite16", rdA16, 16'h0);
    check("sweep_nowrite12", rdA12, 16'h0);
    check("sweep_nowrite_rv", rv16, 1'b1);

    for (int n = 0; n < 500; n++)
      step($urandom_range(0, 99) == 0, 1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 4'($urandom), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
